// File: rtl/bus_arb_pkg.sv
// bus_arb_pkg: shared types and constants for the bus arbiter.
//   arb_state_t      - arbiter FSM state (IDLE / GRANT / RELEASE)
//   DEFAULT_NUM_REQ  - default number of requesting masters
//   DEFAULT_MAX_HOLD - default grant cycles before preemption is requested
//   id_width()       - width of the owner index for a given master count
package bus_arb_pkg;

  localparam int DEFAULT_NUM_REQ  = 2;
  localparam int DEFAULT_MAX_HOLD = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } arb_state_t;

  function automatic int id_width(input int num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

endpackage

// File: rtl/bus_arbiter_rr_picker.sv
// rr_picker: combinational round-robin selector.
//   i_req    [NUM_REQ] - request vector
//   i_ptr    [IW]      - index of the previous winner; search starts at i_ptr+1
//   o_winner [IW]      - first requesting index at or after i_ptr+1, wrapping
//   o_valid            - at least one request is present
module rr_picker
  import bus_arb_pkg::*;
#(
  parameter int NUM_REQ = DEFAULT_NUM_REQ,
  parameter int IW      = id_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IW-1:0]      i_ptr,
  output logic [IW-1:0]      o_winner,
  output logic               o_valid
);

  logic [2*NUM_REQ-1:0] w_dbl;
  logic [NUM_REQ-1:0]   w_rot;
  int                   w_base;
  int                   w_sel;

  // Doubling the vector lets a plain shift rotate it so that bit 0 is the
  // first candidate after the pointer.
  assign w_dbl = {i_req, i_req};

  always_comb begin
    w_base   = int'(i_ptr) + 1;
    w_rot    = NUM_REQ'(w_dbl >> w_base);
    w_sel    = 0;
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      if (w_rot[j]) w_sel = j;
    end
    o_valid  = |i_req;
    o_winner = IW'((w_base + w_sel) % NUM_REQ);
  end

endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin owner selection for the shared memory bus.
//   clk      - clock, rising edge
//   rst      - synchronous active-high reset
//   req      - level request per master
//   frame    - current owner has a transfer in progress
//   gnt      - registered one-hot grant, zero when no owner
//   gnt_id   - index of the current (or last) owner
//   bus_busy - high in GRANT and RELEASE
//   preempt  - owner is asked to finish (timeout build only)
// Build option: define BUS_ARB_TIMEOUT_EN to add the hold-timeout counter
// that raises preempt after MAX_HOLD grant cycles while others wait.
//
// state   | meaning
// IDLE    | no owner, arbitrate among requests
// GRANT   | owner holds the bus until req and frame are both low
// RELEASE | one dead turnaround cycle, no grant
module bus_arbiter
  import bus_arb_pkg::*;
#(
  parameter  int NUM_REQ  = DEFAULT_NUM_REQ,
  parameter  int MAX_HOLD = DEFAULT_MAX_HOLD,
  localparam int IW       = id_width(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               frame,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IW-1:0]      gnt_id,
  output logic               bus_busy,
  output logic               preempt
);

  if (NUM_REQ < 2 || NUM_REQ > 8 || MAX_HOLD < 1) begin : g_param_check
    $error("bus_arbiter: illegal NUM_REQ or MAX_HOLD");
  end

  arb_state_t         r_state, w_state_nxt;
  logic [NUM_REQ-1:0] r_gnt, w_gnt_nxt;
  logic [IW-1:0]      r_gnt_id, w_gnt_id_nxt;
  logic [IW-1:0]      r_last_owner, w_last_nxt;
  logic [IW-1:0]      w_winner;
  logic               w_valid;
  logic               w_owner_req;
  logic               w_release;

  rr_picker #(.NUM_REQ(NUM_REQ), .IW(IW)) u_picker (
    .i_req    (req),
    .i_ptr    (r_last_owner),
    .o_winner (w_winner),
    .o_valid  (w_valid)
  );

  assign w_owner_req = |(req & r_gnt);
  assign w_release   = (r_state == GRANT) && !w_owner_req && !frame;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_gnt        <= '0;
      r_gnt_id     <= '0;
      r_last_owner <= IW'(NUM_REQ - 1);
    end else begin
      r_state      <= w_state_nxt;
      r_gnt        <= w_gnt_nxt;
      r_gnt_id     <= w_gnt_id_nxt;
      r_last_owner <= w_last_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_gnt_nxt    = r_gnt;
    w_gnt_id_nxt = r_gnt_id;
    w_last_nxt   = r_last_owner;
    case (r_state)
      IDLE: begin
        if (w_valid) begin
          w_gnt_nxt    = {{(NUM_REQ-1){1'b0}}, 1'b1} << w_winner;
          w_gnt_id_nxt = w_winner;
          w_last_nxt   = w_winner;
          w_state_nxt  = GRANT;
        end
      end
      GRANT: begin
        // Other masters' requests are deliberately ignored here.
        if (w_release) begin
          w_gnt_nxt   = '0;
          w_state_nxt = RELEASE;
        end
      end
      RELEASE: w_state_nxt = IDLE;
      default: begin
        w_gnt_nxt   = '0;
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign gnt      = r_gnt;
  assign gnt_id   = r_gnt_id;
  assign bus_busy = (r_state != IDLE);

`ifdef BUS_ARB_TIMEOUT_EN
  localparam int HW = $clog2(MAX_HOLD + 1);

  logic [HW-1:0] r_hold;
  logic          r_preempt;
  logic          w_other_req;

  assign w_other_req = |(req & ~r_gnt);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hold    <= '0;
      r_preempt <= 1'b0;
    end else begin
      case (r_state)
        GRANT: begin
          if (r_hold != HW'(MAX_HOLD)) r_hold <= r_hold + HW'(1);
          // preempt is only a request; the FSM still waits for frame low.
          if (w_release) r_preempt <= 1'b0;
          else if (r_hold == HW'(MAX_HOLD) && w_other_req) r_preempt <= 1'b1;
        end
        RELEASE: r_hold <= '0;
        default: ;
      endcase
    end
  end

  assign preempt = r_preempt;
`else
  assign preempt = 1'b0;
`endif

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Grants ownership of the shared memory bus to one of `NUM_REQ` masters: DMA channels raising `BusRequest`, and the CPU. Sits directly downstream of the DMA controller's bus-request output and upstream of the memory bus. Uses round-robin fairness, enforces a one-cycle turnaround between owners, and never revokes a grant in the middle of a framed transfer. An optional hold-timeout requests preemption of a long-running owner.

## Interface
- `NUM_REQ`, default 2: number of requesting masters; legal range 2..8.
- `MAX_HOLD`, default 16: grant cycles before preemption is requested (timeout build only); legal range ≥1.
- `clk` in 1: single clock; all logic on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req` in NUM_REQ: level bus request per master; bit i belongs to master i.
- `frame` in 1: high while the current owner has a transfer in progress.
- `gnt` out NUM_REQ: one-hot grant, registered; all zero when no owner.
- `gnt_id` out $clog2(NUM_REQ): index of the current owner; holds the last owner when idle.
- `bus_busy` out 1: high in GRANT and RELEASE.
- `preempt` out 1: high while the owner is asked to finish (timeout build only; tied 0 otherwise).

## Operation
- States: IDLE, GRANT, RELEASE.
- IDLE:
  - If any `req` bit is high, choose the winner by round-robin, starting at `last_owner+1` mod NUM_REQ and wrapping.
  - Load `gnt`, `gnt_id` and `last_owner`, then go to GRANT.
  - If no `req` bit is high, stay in IDLE.
- GRANT:
  - Stay while `req[gnt_id]` is high or `frame` is high.
  - When both are low at the edge, clear `gnt` and go to RELEASE.
  - Requests from other masters are ignored here; they cannot steal the bus.
- RELEASE: one dead cycle with no grant, then go to IDLE unconditionally.
- Reset values: state IDLE, `gnt` 0, `gnt_id` 0, `last_owner` NUM_REQ-1 (so master 0 wins the first arbitration), `bus_busy` 0, `preempt` 0, hold counter 0.
- If `rst` is asserted mid-grant, it takes effect at that edge: the grant is dropped regardless of `frame`.
- If the owner drops `req` while `frame` is still high, the grant is held until `frame` falls.

## Timing
- Request to grant: `req` sampled high at edge N in IDLE gives `gnt` high after edge N (1-cycle latency).
- Release: `req` and `frame` both low at edge M gives `gnt` low after M and RELEASE during M..M+1. IDLE is reached at M+1, and the next grant is visible after M+2.
- Back-to-back masters therefore see exactly 2 grant-free cycles between owners.
- The same master re-requesting while another master waits loses to that master, because round-robin moves the pointer.
- A lone requester can be re-granted every third cycle.

## Configuration
- `BUS_ARB_TIMEOUT_EN` defined:
  - A hold counter increments every GRANT cycle and saturates at MAX_HOLD.
  - When the counter equals MAX_HOLD and some other `req` bit is high, `preempt` rises on the next edge.
  - `preempt` stays high until the owner releases; the arbiter still waits for `frame` low before revoking.
  - Counter width is $clog2(MAX_HOLD+1); it clears in RELEASE.
- `BUS_ARB_TIMEOUT_EN` undefined: no counter is built, `preempt` is constant 0, and ownership lasts until voluntary release.

## Structure
- Package `bus_arb_pkg` holds:
  - the state enum (IDLE/GRANT/RELEASE),
  - the default NUM_REQ and MAX_HOLD constants,
  - a function returning the `gnt_id` width.
- One sub-module `rr_picker`: combinational. Takes `req` and the pointer, returns `winner` index and `valid`. Unit-testable on its own.

## Test plan
- Reset, then `req`=2'b01 held 4 cycles then dropped (frame 0): `gnt`=01 on cycle 1–4; `gnt`=00 for 2 cycles; `bus_busy` falls after RELEASE.
- `req`=2'b11 held continuously, each owner dropping `req` after 3 grant cycles: grants alternate 01, 10, 01, with exactly 2 zero-grant cycles between them.
- Owner drops `req` while `frame`=1 for 5 more cycles: `gnt` is held until the edge after `frame` falls, then RELEASE.
- `rst` pulsed for 1 cycle during GRANT with `frame`=1: `gnt`=0 the next cycle; the next `req`=2'b11 is granted to master 0.
- Timeout build, MAX_HOLD=4, master 0 holds while master 1 requests: `preempt` rises after the 5th grant cycle. Master 0 ends the frame and releases, and master 1 is granted 2 cycles later.
- Non-timeout build, same stimulus: `preempt` stays 0; master 0 keeps the bus for 50 cycles.
